register_rename_file: RTL and testbench

- Architectural register file plus per-register rename tags.
- Sits between decode (ID) and the reorder buffer.
- ID reads operands through it and renames each new instruction's destination to its ROB id.
- ROB register commits write architectural values. A jump misprediction clears all pending renames.
- Source operands resolve from, in order: the architectural value, the same-cycle commit bypass, or the ROB's ready-value lookup.

---
 rtl/register_rename_file_if.sv | 55 +++++
 rtl/register_rename_file.sv | 91 +++++++++
 tb/tb_register_rename_file.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/register_rename_file_if.sv
// ID/ROB-facing bus of the register rename file.
// Groups the decode, ROB lookup, commit and flush signals.
interface register_rename_file_if #(
  parameter int ROBWD = 4
);
  logic             ID_inst_flag;
  logic             ID_inst_has_rd;
  logic [4:0]       ID_inst_rd;
  logic [31:0]      ID_inst_rob_id;
  logic [4:0]       ID_rs1;
  logic [4:0]       ID_rs2;
  logic             rs1_rdy;
  logic [31:0]      rs1_val;
  logic [31:0]      rs1_rob_id;
  logic             rs2_rdy;
  logic [31:0]      rs2_val;
  logic [31:0]      rs2_rob_id;
  logic [ROBWD-1:0] RF_id1_cut;
  logic [ROBWD-1:0] RF_id2_cut;
  logic             RF_id1_ready;
  logic             RF_id2_ready;
  logic [31:0]      RF_id1_val;
  logic [31:0]      RF_id2_val;
  logic             ROB_cmt_rf_flag;
  logic [4:0]       ROB_cmt_rf_rd;
  logic [31:0]      ROB_cmt_rf_rob_id;
  logic [31:0]      ROB_cmt_rf_val;
  logic             jump_wrong_flag;

  modport master (
    output ID_inst_flag, ID_inst_has_rd, ID_inst_rd,
    output ID_inst_rob_id, ID_rs1, ID_rs2,
    input  rs1_rdy, rs1_val, rs1_rob_id,
    input  rs2_rdy, rs2_val, rs2_rob_id,
    input  RF_id1_cut, RF_id2_cut,
    output RF_id1_ready, RF_id2_ready,
    output RF_id1_val, RF_id2_val,
    output ROB_cmt_rf_flag, ROB_cmt_rf_rd,
    output ROB_cmt_rf_rob_id, ROB_cmt_rf_val,
    output jump_wrong_flag
  );

  modport slave (
    input  ID_inst_flag, ID_inst_has_rd, ID_inst_rd,
    input  ID_inst_rob_id, ID_rs1, ID_rs2,
    output rs1_rdy, rs1_val, rs1_rob_id,
    output rs2_rdy, rs2_val, rs2_rob_id,
    output RF_id1_cut, RF_id2_cut,
    input  RF_id1_ready, RF_id2_ready,
    input  RF_id1_val, RF_id2_val,
    input  ROB_cmt_rf_flag, ROB_cmt_rf_rd,
    input  ROB_cmt_rf_rob_id, ROB_cmt_rf_val,
    input  jump_wrong_flag
  );
endinterface

// File: rtl/register_rename_file.sv
// Architectural register file with per-register rename tags.
// Ports: clk, rst (sync, active high), rdy (global stall), bus (slave).
module register_rename_file #(
  parameter int ROBWD = 4
) (
  input logic clk,
  input logic rst,
  input logic rdy,
  register_rename_file_if.slave bus
);
  logic [31:0] regs [32];
  logic [31:0] tag  [32];
  logic [31:0] busy;

  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] crd;
  logic [4:0] ird;

  assign rs1 = bus.ID_rs1;
  assign rs2 = bus.ID_rs2;
  assign crd = bus.ROB_cmt_rf_rd;
  assign ird = bus.ID_inst_rd;

  assign bus.RF_id1_cut = tag[rs1][ROBWD-1:0];
  assign bus.RF_id2_cut = tag[rs2][ROBWD-1:0];

  // x0 is never renamed or written, so it always resolves as ready 0.
  always_comb begin
    bus.rs1_rdy    = 1'b1;
    bus.rs1_val    = '0;
    bus.rs1_rob_id = '0;
    if (rs1 != 5'd0) begin
      if (!busy[rs1]) begin
        bus.rs1_val = regs[rs1];
      end else if (bus.ROB_cmt_rf_flag && crd == rs1 &&
                   bus.ROB_cmt_rf_rob_id == tag[rs1]) begin
        bus.rs1_val = bus.ROB_cmt_rf_val;
      end else if (bus.RF_id1_ready) begin
        bus.rs1_val = bus.RF_id1_val;
      end else begin
        bus.rs1_rdy    = 1'b0;
        bus.rs1_rob_id = tag[rs1];
      end
    end
  end

  always_comb begin
    bus.rs2_rdy    = 1'b1;
    bus.rs2_val    = '0;
    bus.rs2_rob_id = '0;
    if (rs2 != 5'd0) begin
      if (!busy[rs2]) begin
        bus.rs2_val = regs[rs2];
      end else if (bus.ROB_cmt_rf_flag && crd == rs2 &&
                   bus.ROB_cmt_rf_rob_id == tag[rs2]) begin
        bus.rs2_val = bus.ROB_cmt_rf_val;
      end else if (bus.RF_id2_ready) begin
        bus.rs2_val = bus.RF_id2_val;
      end else begin
        bus.rs2_rdy    = 1'b0;
        bus.rs2_rob_id = tag[rs2];
      end
    end
  end

  // Later assignments win: rename beats the commit's busy clear,
  // and a flush beats both, while the commit value still lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
        tag[i]  <= '0;
      end
      busy <= '0;
    end else if (rdy) begin
      if (bus.ROB_cmt_rf_flag && crd != 5'd0) begin
        regs[crd] <= bus.ROB_cmt_rf_val;
        if (tag[crd] == bus.ROB_cmt_rf_rob_id)
          busy[crd] <= 1'b0;
      end
      if (bus.jump_wrong_flag) begin
        busy <= '0;
      end else if (bus.ID_inst_flag && bus.ID_inst_has_rd &&
                   ird != 5'd0) begin
        busy[ird] <= 1'b1;
        tag[ird]  <= bus.ID_inst_rob_id;
      end
    end
  end
endmodule

// File: tb/tb_register_rename_file.sv
// Directed bench for register_rename_file.
// Drives rename/commit/flush sequences and checks operand outputs.
module tb_register_rename_file;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  register_rename_file_if #(.ROBWD(4)) b ();

  register_rename_file #(.ROBWD(4)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (b)
  );

  task automatic chk(input string t,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", t, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    b.ID_inst_flag    = 1'b0;
    b.ROB_cmt_rf_flag = 1'b0;
    b.jump_wrong_flag = 1'b0;
    b.RF_id1_ready    = 1'b0;
    b.RF_id2_ready    = 1'b0;
  endtask

  task automatic ren(input logic [4:0] rd, input logic [31:0] id);
    b.ID_inst_flag   = 1'b1;
    b.ID_inst_has_rd = 1'b1;
    b.ID_inst_rd     = rd;
    b.ID_inst_rob_id = id;
  endtask

  task automatic cmt(input logic [4:0] rd, input logic [31:0] id,
                     input logic [31:0] v);
    b.ROB_cmt_rf_flag   = 1'b1;
    b.ROB_cmt_rf_rd     = rd;
    b.ROB_cmt_rf_rob_id = id;
    b.ROB_cmt_rf_val    = v;
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    b.ID_inst_flag      = 1'b0;
    b.ID_inst_has_rd    = 1'b0;
    b.ID_inst_rd        = '0;
    b.ID_inst_rob_id    = '0;
    b.ID_rs1            = '0;
    b.ID_rs2            = '0;
    b.RF_id1_ready      = 1'b0;
    b.RF_id2_ready      = 1'b0;
    b.RF_id1_val        = '0;
    b.RF_id2_val        = '0;
    b.ROB_cmt_rf_flag   = 1'b0;
    b.ROB_cmt_rf_rd     = '0;
    b.ROB_cmt_rf_rob_id = '0;
    b.ROB_cmt_rf_val    = '0;
    b.jump_wrong_flag   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    b.ID_rs1 = 5'd5;
    b.ID_rs2 = 5'd0;
    #1;
    chk("rst_rs1_rdy", b.rs1_rdy, 1);
    chk("rst_rs1_val", b.rs1_val, 0);
    chk("rst_rs1_id", b.rs1_rob_id, 0);
    chk("rst_cut1", b.RF_id1_cut, 0);
    chk("rst_x0_rdy", b.rs2_rdy, 1);
    chk("rst_x0_val", b.rs2_val, 0);

    ren(5'd3, 32'd7);
    b.ID_rs1 = 5'd3;
    #1;
    chk("old_map_rdy", b.rs1_rdy, 1);
    step();
    #1;
    chk("pend_rdy", b.rs1_rdy, 0);
    chk("pend_id", b.rs1_rob_id, 7);
    chk("pend_cut", b.RF_id1_cut, 7);
    chk("pend_val", b.rs1_val, 0);
    b.RF_id1_ready = 1'b1;
    b.RF_id1_val   = 32'h55;
    #1;
    chk("robrd_rdy", b.rs1_rdy, 1);
    chk("robrd_val", b.rs1_val, 32'h55);
    b.RF_id1_ready = 1'b0;

    b.ID_rs2 = 5'd3;
    cmt(5'd3, 32'd7, 32'hAB);
    #1;
    chk("byp_rdy", b.rs2_rdy, 1);
    chk("byp_val", b.rs2_val, 32'hAB);
    step();
    #1;
    chk("cmt_rdy", b.rs2_rdy, 1);
    chk("cmt_val", b.rs2_val, 32'hAB);

    ren(5'd4, 32'd9);
    step();
    ren(5'd6, 32'd10);
    step();
    cmt(5'd4, 32'd8, 32'h11);
    b.ID_rs1 = 5'd4;
    #1;
    chk("old_cmt_nobyp", b.rs1_rdy, 0);
    step();
    #1;
    chk("old_cmt_rdy", b.rs1_rdy, 0);
    chk("old_cmt_id", b.rs1_rob_id, 9);
    cmt(5'd6, 32'd10, 32'h66);
    ren(5'd6, 32'd12);
    step();
    b.ID_rs1 = 5'd6;
    #1;
    chk("ren_win_rdy", b.rs1_rdy, 0);
    chk("ren_win_id", b.rs1_rob_id, 12);
    chk("ren_win_cut", b.RF_id1_cut, 12);

    ren(5'd1, 32'd20);
    step();
    ren(5'd2, 32'd21);
    step();
    ren(5'd3, 32'd22);
    step();
    b.ID_rs1 = 5'd1;
    b.ID_rs2 = 5'd2;
    #1;
    chk("x1_id", b.rs1_rob_id, 20);
    chk("x1_cut", b.RF_id1_cut, 4);
    chk("x2_id", b.rs2_rob_id, 21);
    b.jump_wrong_flag = 1'b1;
    cmt(5'd1, 32'd99, 32'h400);
    ren(5'd8, 32'd30);
    step();
    #1;
    chk("fl_x1_rdy", b.rs1_rdy, 1);
    chk("fl_x1_val", b.rs1_val, 32'h400);
    chk("fl_x2_rdy", b.rs2_rdy, 1);
    chk("fl_x2_val", b.rs2_val, 0);
    b.ID_rs1 = 5'd3;
    b.ID_rs2 = 5'd4;
    #1;
    chk("fl_x3_val", b.rs1_val, 32'hAB);
    chk("fl_x4_val", b.rs2_val, 32'h11);
    b.ID_rs1 = 5'd6;
    b.ID_rs2 = 5'd8;
    #1;
    chk("fl_x6_val", b.rs1_val, 32'h66);
    chk("fl_x8_rdy", b.rs2_rdy, 1);

    rdy = 1'b0;
    cmt(5'd5, 32'd0, 32'h123);
    ren(5'd7, 32'd40);
    step();
    rdy = 1'b1;
    b.ID_rs1 = 5'd5;
    b.ID_rs2 = 5'd7;
    #1;
    chk("stall_x5_val", b.rs1_val, 0);
    chk("stall_x7_rdy", b.rs2_rdy, 1);

    ren(5'd0, 32'd50);
    cmt(5'd0, 32'd0, 32'hDEAD);
    step();
    b.ID_rs1 = 5'd0;
    #1;
    chk("x0_rdy", b.rs1_rdy, 1);
    chk("x0_val", b.rs1_val, 0);
    chk("x0_id", b.rs1_rob_id, 0);
    chk("x0_cut", b.RF_id1_cut, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
